pipe_skid_buf: RTL

//  Two-entry skid buffer between a hold-stalled pipeline stage and a ready/valid consumer.
//  - Upstream stalls on hold_o, downstream backpressures with ready_i.
//  - hold_o is registered, so no combinational path runs from ready_i to hold_o.
//  - Sits at the issue/LSU boundary of the core pipeline; full throughput when ready_i=1.

---
 rtl/pipe_skid_buf_pkg.sv | 12 +
 rtl/pipe_skid_buf_if.sv | 23 ++
 rtl/pipe_skid_buf_data_reg.sv | 19 +
 rtl/pipe_skid_buf.sv | 98 +++++++++
 4 files changed

// File: rtl/pipe_skid_buf_pkg.sv
// Shared types for the pipe_skid_buf skid buffer: state encodings and default payload width.
package pipe_skid_buf_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf_if.sv
// Handshake bundle for pipe_skid_buf: upstream hold-stall side plus downstream ready/valid side.
// The flush signal exists only when SKID_FLUSH_EN is defined.
interface pipe_skid_buf_if import pipe_skid_buf_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             hold;
    logic             dn_valid;
    logic [WIDTH-1:0] dn_data;
    logic             ready;
`ifdef SKID_FLUSH_EN
    logic             flush;

    modport slave  (input  up_valid, up_data, ready, flush, output hold, dn_valid, dn_data);
    modport master (output up_valid, up_data, ready, flush, input  hold, dn_valid, dn_data);
`else
    modport slave  (input  up_valid, up_data, ready, output hold, dn_valid, dn_data);
    modport master (output up_valid, up_data, ready, input  hold, dn_valid, dn_data);
`endif

endinterface

// File: rtl/pipe_skid_buf_data_reg.sv
// Enable-loaded payload register with asynchronous active-high clear, used for main and skid entries.
module skid_data_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: hold-stalled upstream stage to ready/valid consumer, registered hold.
// Optional synchronous flush when SKID_FLUSH_EN is defined.
module pipe_skid_buf import pipe_skid_buf_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    pipe_skid_buf_if.slave bus
);

    skid_state_t      state;
    skid_state_t      state_nxt;
    logic             accept;
    logic             send;
    logic             flush;
    logic             main_en;
    logic             skid_en;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

`ifdef SKID_FLUSH_EN
    assign flush = bus.flush;
`else
    assign flush = 1'b0;
`endif

    // Outputs decode from the state register only; ready never reaches hold combinationally.
    assign bus.hold     = (state == SKID_FULL);
    assign bus.dn_valid = (state != SKID_EMPTY);
    assign bus.dn_data  = main_q;

    assign accept = bus.up_valid & ~bus.hold;
    assign send   = bus.dn_valid & bus.ready;
    assign main_d = main_from_skid ? skid_q : bus.up_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= SKID_EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        state_nxt = SKID_ONE;
                        main_en   = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (accept && send) begin
                        main_en = 1'b1;
                    end else if (accept) begin
                        state_nxt = SKID_FULL;
                        skid_en   = 1'b1;
                    end else if (send) begin
                        state_nxt = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (send) begin
                        state_nxt      = SKID_ONE;
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = SKID_EMPTY;
            endcase
        end
    end

    skid_data_reg #(.WIDTH(WIDTH)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    skid_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (bus.up_data),
        .q   (skid_q)
    );

endmodule
